// File: rtl/data_mem.sv
// rtl/data_mem.sv - word-organised data memory with byte/half/word access, error flag and store counter
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high; clears memory, err and st_cnt
//   addr       in   32  byte address (ALU result)
//   wdata      in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//   we         in   1   store request
//   re         in   1   load request (only qualifies error detection)
//   size       in   2   00 word, 01 half, 10 byte, 11 treated as word
//   load_sext  in   1   1: sign-extend half/byte loads, 0: zero-extend
//   pc         in   32  PC of the current instruction (store log only)
//   rdata      out  32  combinational load data, 0 on a bad access
//   misalign   out  1   combinational: addr not aligned to size
//   oor        out  1   combinational: addr beyond 2^(AW+2) bytes
//   err        out  1   sticky error flag, set by a bad load/store
//   st_cnt     out  32  count of committed stores, wraps
module data_mem #(
  parameter int AW     = 12,
  parameter bit LOG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  size,
  input  logic        load_sext,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        oor,
  output logic        err,
  output logic [31:0] st_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [31:0]   mem [0:DEPTH-1];
  logic [AW-1:0] idx;
  logic [31:0]   cur_word;
  logic [31:0]   new_word;
  logic [15:0]   half_val;
  logic [7:0]    byte_val;
  logic          bad;
  logic          commit;

  assign idx      = addr[AW+1:2];
  assign cur_word = mem[idx];
  assign oor      = |addr[31:AW+2];
  assign bad      = misalign | oor;
  // reset priority over the store is applied in the sequential block
  assign commit   = we & ~bad;

  always_comb begin
    misalign = 1'b0;
    case (size)
      2'b01:   misalign = addr[0];
      2'b10:   misalign = 1'b0;
      default: misalign = (addr[1:0] != 2'b00);
    endcase
  end

  // load lane selection and extension
  always_comb begin
    half_val = addr[1] ? cur_word[31:16] : cur_word[15:0];
    byte_val = cur_word[7:0];
    case (addr[1:0])
      2'b01:   byte_val = cur_word[15:8];
      2'b10:   byte_val = cur_word[23:16];
      2'b11:   byte_val = cur_word[31:24];
      default: byte_val = cur_word[7:0];
    endcase
    rdata = cur_word;
    case (size)
      2'b01:   rdata = {{16{load_sext & half_val[15]}}, half_val};
      2'b10:   rdata = {{24{load_sext & byte_val[7]}}, byte_val};
      default: rdata = cur_word;
    endcase
    if (bad) rdata = 32'h0;
  end

  // merge the store data into the addressed byte lanes of the current word
  always_comb begin
    new_word = cur_word;
    case (size)
      2'b01: begin
        if (addr[1]) new_word[31:16] = wdata[15:0];
        else         new_word[15:0]  = wdata[15:0];
      end
      2'b10: begin
        case (addr[1:0])
          2'b01:   new_word[15:8]  = wdata[7:0];
          2'b10:   new_word[23:16] = wdata[7:0];
          2'b11:   new_word[31:24] = wdata[7:0];
          default: new_word[7:0]   = wdata[7:0];
        endcase
      end
      default: new_word = wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      err    <= 1'b0;
      st_cnt <= 32'h0;
    end else begin
      if (commit) begin
        mem[idx] <= new_word;
        st_cnt   <= st_cnt + 32'd1;
        if (LOG_EN) $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, new_word);
      end
      if ((we | re) & bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - table-driven bench for data_mem plus reset/same-cycle sequences
module tb_data_mem;

  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, pc;
  logic        we, re, load_sext;
  logic [1:0]  size;
  logic [31:0] rdata, st_cnt;
  logic        misalign, oor, err;

  int checks = 0;
  int errors = 0;

  data_mem #(.AW(AW), .LOG_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .size(size), .load_sext(load_sext), .pc(pc), .rdata(rdata),
    .misalign(misalign), .oor(oor), .err(err), .st_cnt(st_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_oor;
    logic [31:0] exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [1:0] s, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    we = w; re = r; size = s; load_sext = sx; addr = a; wdata = d;
    pc = pc + 32'd4;
  endtask

  initial begin
    //          we  re  sz    sx  addr         wdata          rdata          mis  oor cnt err
    vecs[0]  = '{1, 0, 2'd0, 0, 32'h0,      32'h12345678, 32'h0,        0, 0, 1, 0};
    vecs[1]  = '{0, 1, 2'd0, 0, 32'h0,      32'h0,        32'h12345678, 0, 0, 1, 0};
    vecs[2]  = '{1, 0, 2'd2, 0, 32'h1,      32'h000000AB, 32'h00000056, 0, 0, 2, 0};
    vecs[3]  = '{0, 1, 2'd0, 0, 32'h0,      32'h0,        32'h1234AB78, 0, 0, 2, 0};
    vecs[4]  = '{0, 1, 2'd2, 1, 32'h1,      32'h0,        32'hFFFFFFAB, 0, 0, 2, 0};
    vecs[5]  = '{0, 1, 2'd2, 0, 32'h1,      32'h0,        32'h000000AB, 0, 0, 2, 0};
    vecs[6]  = '{1, 0, 2'd1, 0, 32'h6,      32'h00008001, 32'h0,        0, 0, 3, 0};
    vecs[7]  = '{0, 1, 2'd0, 0, 32'h4,      32'h0,        32'h80010000, 0, 0, 3, 0};
    vecs[8]  = '{0, 1, 2'd1, 1, 32'h6,      32'h0,        32'hFFFF8001, 0, 0, 3, 0};
    vecs[9]  = '{0, 1, 2'd1, 0, 32'h6,      32'h0,        32'h00008001, 0, 0, 3, 0};
    vecs[10] = '{0, 1, 2'd1, 0, 32'h4,      32'h0,        32'h00000000, 0, 0, 3, 0};
    vecs[11] = '{0, 1, 2'd2, 1, 32'h3,      32'h0,        32'h00000012, 0, 0, 3, 0};
    vecs[12] = '{1, 0, 2'd2, 0, 32'h7,      32'h000000CD, 32'h00000080, 0, 0, 4, 0};
    vecs[13] = '{0, 1, 2'd0, 0, 32'h4,      32'h0,        32'hCD010000, 0, 0, 4, 0};
    vecs[14] = '{0, 1, 2'd3, 0, 32'h0,      32'h0,        32'h1234AB78, 0, 0, 4, 0};
    vecs[15] = '{0, 0, 2'd0, 0, 32'h2,      32'h0,        32'h0,        1, 0, 4, 0};
    vecs[16] = '{1, 0, 2'd0, 0, 32'h2,      32'hDEADBEEF, 32'h0,        1, 0, 4, 1};
    vecs[17] = '{1, 0, 2'd0, 0, 32'h4000,   32'hDEADBEEF, 32'h0,        0, 1, 4, 1};
    vecs[18] = '{0, 1, 2'd0, 0, 32'h0,      32'h0,        32'h1234AB78, 0, 0, 4, 1};
    vecs[19] = '{0, 1, 2'd1, 0, 32'h1,      32'h0,        32'h0,        1, 0, 4, 1};
    vecs[20] = '{0, 0, 2'd0, 0, 32'h0,      32'h0,        32'h1234AB78, 0, 0, 4, 1};

    pc = 32'h00003000;
    reset = 1'b1;
    drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("reset rdata", rdata, 32'h0);
    check("reset err", {31'b0, err}, 32'h0);
    check("reset st_cnt", st_cnt, 32'h0);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].re, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata);
      #2;
      check($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d misalign", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
      check($sformatf("v%0d oor", i), {31'b0, oor}, {31'b0, vecs[i].exp_oor});
      @(posedge clk);
      #1;
      check($sformatf("v%0d st_cnt", i), st_cnt, vecs[i].exp_cnt);
      check($sformatf("v%0d err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
    end

    // reset wins over a simultaneous store
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 2'd0, 0, 32'h0, 32'hFFFFFFFF);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1, 2'd0, 0, 32'h0, 32'h0);
    #2;
    check("rst+we mem0", rdata, 32'h0);
    check("rst+we st_cnt", st_cnt, 32'h0);
    check("rst+we err", {31'b0, err}, 32'h0);
    addr = 32'h4;
    #1;
    check("rst mem1 zeroed", rdata, 32'h0);

    // same-cycle store and load at 8: old data now, new data next cycle
    @(negedge clk);
    drive(1, 1, 2'd0, 0, 32'h8, 32'hCAFEF00D);
    #2;
    check("sw+lw old data", rdata, 32'h0);
    @(negedge clk);
    drive(0, 1, 2'd0, 0, 32'h8, 32'h0);
    #2;
    check("sw+lw new data", rdata, 32'hCAFEF00D);
    check("sw+lw st_cnt", st_cnt, 32'h1);
    check("sw+lw err", {31'b0, err}, 32'h0);

    @(negedge clk);
    drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
